parking_lot_ctrl: RTL and testbench

Sequences the lot occupancy count that feeds the HEX display block. Watches two adjacent gate photo-sensors (outer `a`, inner `b`) and decodes the order in which they are blocked and cleared. Only a complete enter or exit sequence changes the count; partial, reversed or invalid sequences are discarded. Drives `num` (0..CAPACITY) straight into the display block's `num` input, and exposes full/empty flags and one-cycle event pulses.

---
 rtl/parking_lot_ctrl.sv | 129 ++++++++++++
 tb/tb_parking_lot_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/parking_lot_ctrl.sv
// Gate-sensor sequencer for lot occupancy: decodes the blocking order of outer (a)
// and inner (b) beams into enter/exit events and keeps a saturating car count.
module parking_lot_ctrl #(
    parameter int unsigned CAPACITY = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a,
    input  logic       b,
    output logic [4:0] num,
    output logic       enter,
    output logic       exit,
    output logic       full,
    output logic       empty
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EN1  = 3'd1,
        EN2  = 3'd2,
        EN3  = 3'd3,
        EX1  = 3'd4,
        EX2  = 3'd5,
        EX3  = 3'd6
    } state_t;

    localparam logic [4:0] CAP = 5'(CAPACITY);

    state_t     state_q, state_d;
    logic [4:0] num_q, num_d;
    logic       enter_q, enter_d;
    logic       exit_q, exit_d;
    logic [1:0] ab;

    assign ab = {a, b};

    always_comb begin
        state_d = IDLE;
        num_d   = num_q;
        enter_d = 1'b0;
        exit_d  = 1'b0;
        case (state_q)
            IDLE: begin
                case (ab)
                    2'b10:   state_d = EN1;
                    2'b01:   state_d = EX1;
                    default: state_d = IDLE;
                endcase
            end
            EN1: begin
                case (ab)
                    2'b10:   state_d = EN1;
                    2'b11:   state_d = EN2;
                    default: state_d = IDLE;
                endcase
            end
            EN2: begin
                case (ab)
                    2'b11:   state_d = EN2;
                    2'b01:   state_d = EN3;
                    2'b10:   state_d = EN1;
                    default: state_d = IDLE;
                endcase
            end
            EN3: begin
                case (ab)
                    2'b01:   state_d = EN3;
                    2'b11:   state_d = EN2;
                    2'b00: begin
                        state_d = IDLE;
                        enter_d = 1'b1;
                        // Pulse still fires at capacity so an alarm can catch count drift
                        if (num_q < CAP) num_d = num_q + 5'd1;
                    end
                    default: state_d = IDLE;
                endcase
            end
            EX1: begin
                case (ab)
                    2'b01:   state_d = EX1;
                    2'b11:   state_d = EX2;
                    default: state_d = IDLE;
                endcase
            end
            EX2: begin
                case (ab)
                    2'b11:   state_d = EX2;
                    2'b10:   state_d = EX3;
                    2'b01:   state_d = EX1;
                    default: state_d = IDLE;
                endcase
            end
            EX3: begin
                case (ab)
                    2'b10:   state_d = EX3;
                    2'b11:   state_d = EX2;
                    2'b00: begin
                        state_d = IDLE;
                        exit_d  = 1'b1;
                        if (num_q != 5'd0) num_d = num_q - 5'd1;
                    end
                    default: state_d = IDLE;
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            num_q   <= 5'd0;
            enter_q <= 1'b0;
            exit_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            enter_q <= enter_d;
            exit_q  <= exit_d;
        end
    end

    assign num   = num_q;
    assign enter = enter_q;
    assign exit  = exit_q;
    assign full  = (num_q == CAP);
    assign empty = (num_q == 5'd0);

endmodule

// File: tb/tb_parking_lot_ctrl.sv
// Directed bench for parking_lot_ctrl: a pattern-matching occupancy model checked
// every cycle, plus hand-computed expectations at the scenario boundaries.
module tb_parking_lot_ctrl;
    localparam int CAP = 25;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       a = 1'b0;
    logic       b = 1'b0;
    logic [4:0] num;
    logic       enter, exit, full, empty;

    int errors = 0;
    int checks = 0;
    int pulses_en = 0;
    int pulses_ex = 0;

    parking_lot_ctrl #(.CAPACITY(CAP)) dut (
        .clk(clk), .reset(reset), .a(a), .b(b),
        .num(num), .enter(enter), .exit(exit), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    // Model: a sequence is a walk along the pattern 10,11,01,00 (entry) or its
    // a/b mirror (exit); repeat = dwell, next = advance, previous = reversal.
    logic [1:0] seq_en [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
    int  m_num = 0;
    bit  m_en = 0, m_ex = 0;
    int  dir = 0;
    int  pos = 0;

    function automatic logic [1:0] pv(input int d, input int p);
        logic [1:0] v;
        v = seq_en[p];
        return (d == 1) ? v : {v[0], v[1]};
    endfunction

    always @(posedge clk) begin
        logic [1:0] s;
        s = {a, b};
        m_en = 0;
        m_ex = 0;
        if (reset) begin
            m_num = 0;
            dir = 0;
        end else if (dir == 0) begin
            if (s == 2'b10) begin dir = 1; pos = 0; end
            else if (s == 2'b01) begin dir = 2; pos = 0; end
        end else if (s == pv(dir, pos)) begin
        end else if (s == pv(dir, pos + 1)) begin
            pos = pos + 1;
            if (pos == 3) begin
                if (dir == 1) begin
                    m_en = 1;
                    if (m_num < CAP) m_num = m_num + 1;
                end else begin
                    m_ex = 1;
                    if (m_num > 0) m_num = m_num - 1;
                end
                dir = 0;
            end
        end else if (pos > 0 && s == pv(dir, pos - 1)) begin
            pos = pos - 1;
        end else begin
            dir = 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Apply ab for n cycles, comparing every cycle against the model.
    task automatic drive(input logic [1:0] ab, input int n, input logic r = 1'b0);
        for (int i = 0; i < n; i++) begin
            {a, b} = ab;
            reset = r;
            @(posedge clk);
            #1;
            chk("num", 32'(num), 32'(m_num));
            chk("enter", 32'(enter), 32'(m_en));
            chk("exit", 32'(exit), 32'(m_ex));
            chk("full", 32'(full), 32'(m_num == CAP));
            chk("empty", 32'(empty), 32'(m_num == 0));
            if (enter) pulses_en++;
            if (exit) pulses_ex++;
        end
        reset = 1'b0;
    endtask

    task automatic do_entry();
        drive(2'b10, 1); drive(2'b11, 1); drive(2'b01, 1); drive(2'b00, 1);
    endtask

    task automatic do_reset();
        drive(2'b00, 2, 1'b1);
    endtask

    initial begin
        int pe, px;
        do_reset();
        chk("rst_num", 32'(num), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_enter", 32'(enter), 0);

        // Single minimal entry
        drive(2'b10, 1); drive(2'b11, 1); drive(2'b01, 1);
        chk("pre_num", 32'(num), 0);
        drive(2'b00, 1);
        chk("e1_enter", 32'(enter), 1);
        chk("e1_num", 32'(num), 1);
        chk("e1_empty", 32'(empty), 0);
        drive(2'b00, 1);
        chk("e1_clear", 32'(enter), 0);

        // Slow exit from 3
        do_entry(); do_entry();
        chk("n3", 32'(num), 3);
        px = pulses_ex;
        drive(2'b01, 3); drive(2'b11, 3); drive(2'b10, 3);
        drive(2'b00, 1);
        chk("x_exit", 32'(exit), 1);
        chk("x_num", 32'(num), 2);
        drive(2'b00, 2);
        chk("x_pulses", 32'(pulses_ex - px), 1);

        // Aborted entries: reversal then invalid
        pe = pulses_en; px = pulses_ex;
        drive(2'b10, 1); drive(2'b11, 1); drive(2'b10, 1); drive(2'b00, 2);
        drive(2'b10, 1); drive(2'b01, 1); drive(2'b00, 2);
        // Reversal inside a sequence that still completes
        drive(2'b10, 1); drive(2'b11, 1); drive(2'b01, 1); drive(2'b11, 1);
        drive(2'b01, 1); drive(2'b00, 1);
        chk("rev_num", 32'(num), 3);
        drive(2'b01, 1); drive(2'b11, 1); drive(2'b00, 2);
        chk("abort_num", 32'(num), 3);
        chk("abort_pulses", 32'(pulses_en - pe + pulses_ex - px), 1);

        // Fill to capacity and saturate
        do_reset();
        for (int i = 0; i < 24; i++) do_entry();
        chk("n24_full", 32'(full), 0);
        do_entry();
        chk("n25_num", 32'(num), 25);
        chk("n25_full", 32'(full), 1);
        do_entry();
        chk("sat_enter", 32'(enter), 1);
        chk("sat_num", 32'(num), 25);

        // Exit at empty
        do_reset();
        drive(2'b01, 1); drive(2'b11, 1); drive(2'b10, 1); drive(2'b00, 1);
        chk("uf_exit", 32'(exit), 1);
        chk("uf_num", 32'(num), 0);
        chk("uf_empty", 32'(empty), 1);

        // Reset mid-sequence, then back-to-back entries
        do_reset();
        for (int i = 0; i < 5; i++) do_entry();
        chk("n5", 32'(num), 5);
        drive(2'b10, 1); drive(2'b11, 1); drive(2'b01, 1);
        drive(2'b00, 1, 1'b1);
        chk("mr_enter", 32'(enter), 0);
        chk("mr_num", 32'(num), 0);
        drive(2'b00, 1);
        chk("mr_idle", 32'(enter), 0);
        pe = pulses_en;
        do_entry(); do_entry();
        drive(2'b00, 1);
        chk("b2b_num", 32'(num), 2);
        chk("b2b_pulses", 32'(pulses_en - pe), 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
